// File: rtl/mem_map_pkg.sv
// MMIO address map and status bit layout for the mem_responder window.
// Everything at 0xFFxx is MMIO; all other addresses go to backing RAM.
package mem_map_pkg;
  localparam logic [7:0] MMIO_BASE      = 8'hFF;
  localparam logic [7:0] OFS_OUT_DATA   = 8'h00;
  localparam logic [7:0] OFS_OUT_STATUS = 8'h01;
  localparam logic [7:0] OFS_CYCLE_LO   = 8'h02;
  localparam logic [7:0] OFS_CYCLE_HI   = 8'h03;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  function automatic logic is_mmio(input logic [15:0] addr);
    return addr[15:8] == MMIO_BASE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an occupancy counter. A pop frees a slot for a
// push in the same cycle, so a full FIFO still accepts a push while draining.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty = count_q == '0;
  assign full  = count_q == (AW+1)'(DEPTH);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mem_responder.sv
// BRAM-compatible responder: RAM plus MMIO window (output FIFO, cycle counter),
// one-cycle registered read latency, read-first on same-address write.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_AW  = 12,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bram_addra,
  input  logic [15:0] bram_dina,
  input  logic        bram_wea,
  output logic [15:0] bram_douta,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
);
  localparam int FIFO_DEPTH = 2 ** FIFO_AW;

  logic [15:0]       ram [2**RAM_AW];
  logic [15:0]       ram_rd_q;
  logic [RAM_AW-1:0] ram_idx;
  logic              mmio;
  logic [7:0]        ofs;

  logic              sel_ram_q, sel_ram_d;
  logic [15:0]       mmio_rd_q, mmio_rd_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [15:0]       hi_shadow_q, hi_shadow_d;

  logic              push, pop, fifo_full, fifo_empty;
  logic [FIFO_AW:0]  fifo_count;

  assign mmio    = is_mmio(bram_addra);
  assign ofs     = bram_addra[7:0];
  assign ram_idx = bram_addra[RAM_AW-1:0];

  // Plain array with unreset output register so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (bram_wea && !mmio) ram[ram_idx] <= bram_dina;
    ram_rd_q <= ram[ram_idx];
  end

  sync_fifo #(.WIDTH(16), .AW(FIFO_AW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (bram_dina),
    .pop  (pop),
    .dout (out_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  always_comb begin
    push        = mmio && bram_wea && ofs == OFS_OUT_DATA;
    sel_ram_d   = !mmio;
    cycle_d     = cycle_q + 32'd1;
    hi_shadow_d = hi_shadow_q;
    mmio_rd_d   = '0;
    ovf_d       = ovf_q;
    if (mmio) begin
      case (ofs)
        OFS_OUT_STATUS: begin
          mmio_rd_d[ST_OVF]   = ovf_q;
          mmio_rd_d[ST_FULL]  = fifo_full;
          mmio_rd_d[ST_EMPTY] = fifo_empty;
        end
        OFS_CYCLE_LO: begin
          mmio_rd_d   = cycle_q[15:0];
          hi_shadow_d = cycle_q[31:16];
        end
        OFS_CYCLE_HI: mmio_rd_d = hi_shadow_q;
        default:      mmio_rd_d = '0;
      endcase
    end
    if (mmio && bram_wea && ofs == OFS_OUT_STATUS && bram_dina[ST_OVF]) ovf_d = 1'b0;
    // Set after clear so a drop in the same cycle keeps the flag.
    if (push && fifo_count == (FIFO_AW+1)'(FIFO_DEPTH) && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_ram_q   <= 1'b0;
      mmio_rd_q   <= '0;
      ovf_q       <= 1'b0;
      cycle_q     <= '0;
      hi_shadow_q <= '0;
    end else begin
      sel_ram_q   <= sel_ram_d;
      mmio_rd_q   <= mmio_rd_d;
      ovf_q       <= ovf_d;
      cycle_q     <= cycle_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign bram_douta = sel_ram_q ? ram_rd_q : mmio_rd_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM aliasing/read-first, FIFO overflow and
// full-with-pop, cycle counter hi shadow, asynchronous reset mid-transfer.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bram_addra, bram_dina, bram_douta, out_data;
  logic        bram_wea, out_valid, out_ready;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] q;
  logic [15:0] exp_a [8];
  logic [15:0] exp_b [8];

  mem_responder #(.RAM_AW(12), .FIFO_AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bram_addra(bram_addra),
    .bram_dina (bram_dina),
    .bram_wea  (bram_wea),
    .bram_douta(bram_douta),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus beat: drive at negedge, return read data just after the edge.
  task automatic beat(input logic [15:0] a, input logic [15:0] d, input logic w,
                      output logic [15:0] rd);
    @(negedge clk);
    bram_addra = a;
    bram_dina  = d;
    bram_wea   = w;
    @(posedge clk);
    #1;
    rd = bram_douta;
  endtask

  task automatic drain(input string tag, input logic [15:0] exp [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bram_wea  = 1'b0;
      out_ready = 1'b1;
      #1;
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({tag, "_data"}, {16'b0, out_data}, {16'b0, exp[i]});
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check({tag, "_empty"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    bram_addra = '0;
    bram_dina  = '0;
    bram_wea   = 1'b0;
    out_ready  = 1'b0;
    #1;
    check("rst_douta", {16'b0, bram_douta}, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("rst_status", {16'b0, q}, 32'h1);

    // RAM write, read-back and aliasing
    beat(16'h0010, 16'h1234, 1'b1, q);
    beat(16'h0010, 16'h0000, 1'b0, q);
    check("ram_rd", {16'b0, q}, 32'h1234);
    beat(16'h1010, 16'h0000, 1'b0, q);
    check("ram_alias", {16'b0, q}, 32'h1234);

    // read-first on same-address write
    beat(16'h0020, 16'h0001, 1'b1, q);
    beat(16'h0020, 16'hBEEF, 1'b1, q);
    check("rd_first_old", {16'b0, q}, 32'h0001);
    beat(16'h0020, 16'h0000, 1'b0, q);
    check("rd_first_new", {16'b0, q}, 32'hBEEF);

    // overflow: 9 pushes into 8 slots
    for (int i = 0; i < 9; i++) beat(16'hFF00, 16'h00A0 + 16'(i), 1'b1, q);
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("ovf_status", {16'b0, q}, 32'h6);
    for (int i = 0; i < 8; i++) exp_a[i] = 16'h00A0 + 16'(i);
    drain("ovf_drain", exp_a);
    beat(16'hFF01, 16'h0004, 1'b1, q);
    check("clr_status_pre", {16'b0, q}, 32'h5);
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("clr_status", {16'b0, q}, 32'h1);

    // full FIFO, push and pop in the same cycle
    for (int i = 0; i < 8; i++) beat(16'hFF00, 16'h00B0 + 16'(i), 1'b1, q);
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("full_status", {16'b0, q}, 32'h2);
    out_ready = 1'b1;
    beat(16'hFF00, 16'h0055, 1'b1, q);
    out_ready = 1'b0;
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("full_pp_status", {16'b0, q}, 32'h2);
    for (int i = 0; i < 7; i++) exp_b[i] = 16'h00B1 + 16'(i);
    exp_b[7] = 16'h0055;
    drain("pp_drain", exp_b);

    // other MMIO reads return zero
    beat(16'hFF00, 16'h0, 1'b0, q);
    check("outdata_rd", {16'b0, q}, 32'h0);
    beat(16'hFF10, 16'h0, 1'b0, q);
    check("mmio_hole", {16'b0, q}, 32'h0);

    // counter carry between LO and HI reads
    @(negedge clk);
    bram_addra = 16'hFF02;
    bram_wea   = 1'b0;
    force dut.cycle_q = 32'h0001_FFFF;
    #1;
    release dut.cycle_q;
    @(posedge clk);
    #1;
    check("cyc_lo", {16'b0, bram_douta}, 32'hFFFF);
    beat(16'hFF03, 16'h0, 1'b0, q);
    check("cyc_hi", {16'b0, q}, 32'h0001);

    // async reset with words queued while popping
    for (int i = 0; i < 3; i++) beat(16'hFF00, 16'h00C0 + 16'(i), 1'b1, q);
    beat(16'h0010, 16'h0, 1'b0, q);
    check("pre_rst_rd", {16'b0, q}, 32'h1234);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("pre_rst_head", {16'b0, out_data}, 32'h00C0);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    check("mid_rst_douta", {16'b0, bram_douta}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    beat(16'hFF01, 16'h0, 1'b0, q);
    check("post_rst_status", {16'b0, q}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
